// File: rtl/mcp3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcp3_pkg
// Description : Shared constants for the MCP3 per-requester request queue.
//               Requester count, winner index width and the encoding of a
//               2-deep slot occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
package mcp3_pkg;

    localparam int MCP3_NREQ   = 16;
    localparam int MCP3_NREQ_W = 4;

    // Slot occupancy encoding (count of valid entries, 0..2)
    localparam logic [1:0] SLOT_EMPTY = 2'd0;
    localparam logic [1:0] SLOT_ONE   = 2'd1;
    localparam logic [1:0] SLOT_FULL  = 2'd2;

endpackage : mcp3_pkg
`default_nettype wire

// File: rtl/mcp3_reqq_slot.sv
`default_nettype none
// ============================================================================
// Module      : mcp3_reqq_slot
// Description : One 2-deep FIFO slot. Holds a registered occupancy count and
//               two payload entries (entry0 is the head).
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset (clears count only)
//   i_push      in   push request (ignored while full)
//   i_pop       in   pop request (ignored while empty)
//   i_din       in   payload to push
//   o_head      out  head entry (entry0)
//   o_nonempty  out  slot holds at least one entry
//   o_full      out  slot holds two entries
// Revision    : 1.0 - initial release
// ============================================================================
module mcp3_reqq_slot
    import mcp3_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_nonempty,
    output logic             o_full
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_entry0;
    logic [WIDTH-1:0] r_entry1;

    logic w_push;
    logic w_pop;

    // Gating uses only registered state, so readiness never depends on pop.
    assign w_push = i_push & (r_count != SLOT_FULL);
    assign w_pop  = i_pop  & (r_count != SLOT_EMPTY);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= SLOT_EMPTY;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is not reset; validity is carried by r_count alone.
    // Push+pop together can only happen at count 1 (push is blocked at 2),
    // so the new word lands in entry0 and overrides the shift.
    always_ff @(posedge clock) begin
        if (w_pop) begin
            r_entry0 <= r_entry1;
        end
        if (w_push) begin
            if ((r_count == SLOT_ONE) && !w_pop) begin
                r_entry1 <= i_din;
            end else begin
                r_entry0 <= i_din;
            end
        end
    end

    assign o_head     = r_entry0;
    assign o_nonempty = (r_count != SLOT_EMPTY);
    assign o_full     = (r_count == SLOT_FULL);

endmodule : mcp3_reqq_slot
`default_nettype wire

// File: rtl/mcp3_reqq016.sv
`default_nettype none
// ============================================================================
// Module      : mcp3_reqq016
// Description : 16-requester request queue in front of the round-robin
//               arbiter. Each engine owns a 2-deep slot; occupancy flags go
//               to the arbiter, req_clear pops slot heads, and the head of
//               the current winner is muxed onto a single output.
//   clock, reset        clock / synchronous active-high reset
//   in_valid/in_data    per-engine push (engine i at [i*WIDTH +: WIDTH])
//   in_ready            per-engine slot not full
//   req_bus             slot non-empty
//   req_bus_2pending    slot full
//   req_clear           per-slot pop from the arbiter (multi-hot allowed)
//   winner/winner_valid arbiter's encoded winner
//   out_valid/out_data  head payload of the winner slot
// Revision    : 1.0 - initial release
// ============================================================================
module mcp3_reqq016
    import mcp3_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [MCP3_NREQ-1:0]         in_valid,
    input  logic [MCP3_NREQ*WIDTH-1:0]   in_data,
    output logic [MCP3_NREQ-1:0]         in_ready,
    output logic [MCP3_NREQ-1:0]         req_bus,
    output logic [MCP3_NREQ-1:0]         req_bus_2pending,
    input  logic [MCP3_NREQ-1:0]         req_clear,
    input  logic [MCP3_NREQ_W-1:0]       winner,
    input  logic                         winner_valid,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data
);

    logic [WIDTH-1:0]     w_head [MCP3_NREQ];
    logic [MCP3_NREQ-1:0] w_full;

    generate
        for (genvar gi = 0; gi < MCP3_NREQ; gi++) begin : g_slot
            mcp3_reqq_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clock      (clock),
                .reset      (reset),
                .i_push     (in_valid[gi]),
                .i_pop      (req_clear[gi]),
                .i_din      (in_data[gi*WIDTH +: WIDTH]),
                .o_head     (w_head[gi]),
                .o_nonempty (req_bus[gi]),
                .o_full     (w_full[gi])
            );
        end
    endgenerate

    assign req_bus_2pending = w_full;
    assign in_ready         = ~w_full;

    assign out_data  = w_head[winner];
    assign out_valid = winner_valid & req_bus[winner];

endmodule : mcp3_reqq016
`default_nettype wire

// File: tb/tb_mcp3_reqq016.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcp3_reqq016
// Description : Self-checking bench for mcp3_reqq016. A queue-per-slot model
//               tracks the expected contents; every cycle the flags and the
//               winner mux are compared against it. Directed scenarios pin
//               the model with literal expectations, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcp3_reqq016;

    localparam int W = 64;
    localparam int N = 16;

    logic             clock;
    logic             reset;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic [N-1:0]     req_bus;
    logic [N-1:0]     req_bus_2pending;
    logic [N-1:0]     req_clear;
    logic [3:0]       winner;
    logic             winner_valid;
    logic             out_valid;
    logic [W-1:0]     out_data;

    int tests_run = 0;
    int tests_failed = 0;

    mcp3_reqq016 #(.WIDTH(W)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .req_bus          (req_bus),
        .req_bus_2pending (req_bus_2pending),
        .req_clear        (req_clear),
        .winner           (winner),
        .winner_valid     (winner_valid),
        .out_valid        (out_valid),
        .out_data         (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model: one queue per slot ----------------
    logic [W-1:0] mq [N][$];
    bit           model_live = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            model_live = 1'b1;
        end else if (model_live) begin
            for (int i = 0; i < N; i++) begin
                bit can_push;
                can_push = (mq[i].size() < 2);
                if (req_clear[i] && mq[i].size() > 0) void'(mq[i].pop_front());
                if (in_valid[i] && can_push) mq[i].push_back(in_data[i*W +: W]);
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clock) begin
        if (model_live && !reset) begin
            logic [N-1:0] e_bus, e_2p, e_rdy;
            logic         e_ov;
            for (int i = 0; i < N; i++) begin
                e_bus[i] = (mq[i].size() != 0);
                e_2p[i]  = (mq[i].size() == 2);
                e_rdy[i] = (mq[i].size() != 2);
            end
            e_ov = winner_valid && (mq[winner].size() != 0);
            check("req_bus",  W'(req_bus), W'(e_bus));
            check("req_2p",   W'(req_bus_2pending), W'(e_2p));
            check("in_ready", W'(in_ready), W'(e_rdy));
            check("out_valid", W'(out_valid), W'(e_ov));
            if (e_ov) check("out_data", out_data, mq[winner][0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        in_valid  = '0;
        req_clear = '0;
    endtask

    task automatic put(input int slot, input logic [W-1:0] d);
        in_valid[slot]          = 1'b1;
        in_data[slot*W +: W]    = d;
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = '0;
        in_data      = '0;
        req_clear    = '0;
        winner       = '0;
        winner_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_req_bus",  W'(req_bus), 64'h0);
        check("rst_2p",       W'(req_bus_2pending), 64'h0);
        check("rst_in_ready", W'(in_ready), 64'hFFFF);
        check("rst_out_valid", W'(out_valid), 64'h0);

        // Single push to slot 3
        put(3, 64'hA5);
        step();
        idle();
        winner = 4'd3; winner_valid = 1'b1;
        #1;
        check("push3_req_bus", W'(req_bus), 64'h0008);
        check("push3_ov",      W'(out_valid), 64'h1);
        check("push3_data",    out_data, 64'hA5);

        // Fill slot 15, overflow push dropped, drain in order
        put(15, 64'h11); step();
        put(15, 64'h22); step();
        check("s15_2p",   W'(req_bus_2pending[15]), 64'h1);
        check("s15_rdy",  W'(in_ready[15]), 64'h0);
        put(15, 64'h33); step();
        idle();
        winner = 4'd15;
        #1;
        check("s15_head0", out_data, 64'h11);
        req_clear[15] = 1'b1; step();
        check("s15_head1", out_data, 64'h22);
        step();
        idle();
        #1;
        check("s15_empty", W'(req_bus[15]), 64'h0);

        // Slot 7 simultaneous push and pop at count 1
        put(7, 64'h01); step();
        put(7, 64'h02); req_clear[7] = 1'b1; step();
        idle();
        winner = 4'd7;
        #1;
        check("s7_bus",  W'(req_bus[7]), 64'h1);
        check("s7_2p",   W'(req_bus_2pending[7]), 64'h0);
        check("s7_head", out_data, 64'h02);

        // Pop on empty slot 0
        req_clear[0] = 1'b1; step();
        idle();
        #1;
        check("pop_empty_bus", W'(req_bus), 64'h0088);
        check("pop_empty_rdy", W'(in_ready), 64'hFFFF);

        // Multi-hot clear on two full slots
        put(0, 64'hB0); put(15, 64'hF0); step();
        put(0, 64'hB1); put(15, 64'hF1); step();
        idle();
        req_clear = 16'h8001; step();
        idle();
        #1;
        check("mh_2p",  W'(req_bus_2pending), 64'h0);
        check("mh_bus", W'(req_bus), 64'h8089);
        winner = 4'd0;  #1;
        check("mh_head0", out_data, 64'hB1);
        winner = 4'd15; #1;
        check("mh_head15", out_data, 64'hF1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                in_valid[i]       = ($urandom_range(0, 99) < 45);
                req_clear[i]      = ($urandom_range(0, 99) < 40);
                in_data[i*W +: W] = {$urandom, $urandom};
            end
            winner       = 4'($urandom_range(0, 15));
            winner_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        // Fill everything, then reset with concurrent pushes
        idle();
        for (int i = 0; i < N; i++) put(i, W'(64'hC000 + i));
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < N; i++) put(i, W'(64'hD000 + i));
        step();
        reset = 1'b0;
        idle();
        winner_valid = 1'b1;
        #1;
        check("mrst_bus", W'(req_bus), 64'h0);
        check("mrst_2p",  W'(req_bus_2pending), 64'h0);
        check("mrst_rdy", W'(in_ready), 64'hFFFF);
        check("mrst_ov",  W'(out_valid), 64'h0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_mcp3_reqq016
`default_nettype wire
